// File: rtl/pc_pkg.sv
// Shared constants and types for the per-core program-counter unit.
package pc_pkg;

  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  localparam int unsigned NZP_W = 3;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_CALL   = 2'b10,
    PC_RET    = 2'b11
  } pc_mux_e;

endpackage

// File: rtl/return_stack.sv
// Per-lane LIFO of return addresses. The pointer counts valid entries (0..DEPTH).
// Pushes onto a full stack and pops from an empty stack are ignored here.
// The caller flags those cases.
module return_stack
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign full   = (ptr == PTR_W'(DEPTH));
  assign empty  = (ptr == '0);
  assign wr_idx = IDX_W'(ptr);
  assign rd_idx = IDX_W'(ptr - PTR_W'(1));
  assign top    = empty ? '0 : mem[rd_idx];

  // Stack pointer: the only state that reset must clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PTR_W'(1);
    end else if (pop && !empty) begin
      ptr <= ptr - PTR_W'(1);
    end
  end

  // Entry storage; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Per-core program-counter unit: per-lane NZP register and registered next PC.
// Optional feature macro PC_RAS_EN adds per-lane call/return stacks and sticky
// overflow/underflow flags. Without it, call/return codes act as sequential flow.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned THREADS               = 4,
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned DATA_MEM_DATA_BITS    = 8,
  parameter int unsigned RAS_DEPTH             = 4
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     enable,
  input  logic [THREADS-1:0]                       thread_enable,
  input  logic [2:0]                               core_state,
  input  logic [2:0]                               decoded_nzp,
  input  logic [DATA_MEM_DATA_BITS-1:0]            decoded_immediate,
  input  logic                                     decoded_nzp_write_enable,
  input  logic [1:0]                               decoded_pc_mux,
  input  logic [THREADS*DATA_MEM_DATA_BITS-1:0]    alu_out,
  input  logic [THREADS*PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic [THREADS*PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  output logic [THREADS-1:0]                       ras_overflow,
  output logic [THREADS-1:0]                       ras_underflow
);

  localparam int unsigned PC_W   = PROGRAM_MEM_ADDR_BITS;
  localparam int unsigned DATA_W = DATA_MEM_DATA_BITS;

  pc_mux_e         mux_sel;
  logic [PC_W-1:0] target;
  logic            unused_inputs;

  assign mux_sel = pc_mux_e'(decoded_pc_mux);
  // Width cast truncates or zero-extends the immediate to the PC width.
  assign target  = PC_W'(decoded_immediate);
  assign unused_inputs = ^{alu_out, decoded_immediate, 32'(RAS_DEPTH)};

`ifndef PC_RAS_EN
  assign ras_overflow  = '0;
  assign ras_underflow = '0;
`endif

  for (genvar i = 0; i < THREADS; i++) begin : g_lane
    logic [PC_W-1:0]  cur_pc;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_nxt;
    logic [PC_W-1:0]  next_pc_q;
    logic [NZP_W-1:0] nzp_q;
    logic             lane_go;
    logic             exec;
    logic             upd;

    assign cur_pc  = current_pc[i*PC_W +: PC_W];
    assign pc_inc  = cur_pc + PC_W'(1);
    assign lane_go = enable && thread_enable[i];
    assign exec    = lane_go && (core_state == CORE_EXECUTE);
    assign upd     = lane_go && (core_state == CORE_UPDATE) && decoded_nzp_write_enable;
    assign next_pc[i*PC_W +: PC_W] = next_pc_q;

`ifdef PC_RAS_EN
    logic            push;
    logic            pop;
    logic            set_ovf;
    logic            set_unf;
    logic            ovf_q;
    logic            unf_q;
    logic [PC_W-1:0] ras_top;
    logic            ras_full;
    logic            ras_empty;

    return_stack #(
      .DEPTH (RAS_DEPTH),
      .WIDTH (PC_W)
    ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top       (ras_top),
      .full      (ras_full),
      .empty     (ras_empty)
    );

    assign ras_overflow[i]  = ovf_q;
    assign ras_underflow[i] = unf_q;
`endif

    // Next-PC selection and stack requests for this lane.
    always_comb begin
      pc_nxt = pc_inc;
`ifdef PC_RAS_EN
      push    = 1'b0;
      pop     = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
`endif
      case (mux_sel)
        PC_BRANCH: begin
          if ((nzp_q & decoded_nzp) != '0) pc_nxt = target;
        end
`ifdef PC_RAS_EN
        PC_CALL: begin
          pc_nxt  = target;
          push    = exec && !ras_full;
          set_ovf = exec && ras_full;
        end
        PC_RET: begin
          if (ras_empty) begin
            set_unf = exec;
          end else begin
            pc_nxt = ras_top;
            pop    = exec;
          end
        end
`endif
        default: ;
      endcase
    end

    // Lane state: next PC on EXECUTE, NZP on UPDATE.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        next_pc_q <= '0;
        nzp_q     <= '0;
      end else begin
        if (exec) next_pc_q <= pc_nxt;
        if (upd)  nzp_q     <= alu_out[i*DATA_W +: NZP_W];
      end
    end

`ifdef PC_RAS_EN
    // Sticky stack error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
      end else begin
        ovf_q <= ovf_q | set_ovf;
        unf_q <= unf_q | set_unf;
      end
    end
`endif
  end

endmodule
